// File: rtl/counter_8bits_down_if.sv
// Control and data bundle for the 8-bit down counter: stimulus side (master)
// and counter side (slave).
interface counter_8bits_down_if;
    logic       Load_N;
    logic       Clear_N;
    logic       P;
    logic       T;
    logic       Reload_En;
    logic [3:0] Din1;
    logic [3:0] Din2;
    logic [3:0] Qout1;
    logic [3:0] Qout2;
    logic [1:0] Borrow;
    logic       Zero;

    modport master (
        output Load_N, Clear_N, P, T, Reload_En, Din1, Din2,
        input  Qout1, Qout2, Borrow, Zero
    );

    modport slave (
        input  Load_N, Clear_N, P, T, Reload_En, Din1, Din2,
        output Qout1, Qout2, Borrow, Zero
    );
endinterface

// File: rtl/counter_8bits_down.sv
// 8-bit down counter of two cascaded 4-bit digits with auto-reload register,
// binary or BCD digit range selected by BCD.
module counter_8bits_down #(
    parameter int unsigned BCD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_8bits_down_if.slave  bus
);

    localparam logic [3:0] DigitMax = (BCD != 0) ? 4'd9 : 4'd15;

    logic [3:0] q1_q, q1_d;
    logic [3:0] q2_q, q2_d;
    logic [3:0] r1_q, r1_d;
    logic [3:0] r2_q, r2_d;

    logic q1_zero;
    logic q2_zero;

    assign q1_zero = (q1_q == 4'd0);
    assign q2_zero = (q2_q == 4'd0);

    // Out-of-range BCD digits simply decrement down into 9..0.
    function automatic logic [3:0] dec_digit(input logic [3:0] v);
        return (v == 4'd0) ? DigitMax : v - 4'd1;
    endfunction

    always_comb begin
        q1_d = q1_q;
        q2_d = q2_q;
        r1_d = r1_q;
        r2_d = r2_q;
        if (!bus.Clear_N) begin
            q1_d = 4'd0;
            q2_d = 4'd0;
        end else if (!bus.Load_N) begin
            q1_d = bus.Din1;
            q2_d = bus.Din2;
            r1_d = bus.Din1;
            r2_d = bus.Din2;
        end else if (bus.P && bus.T) begin
            if (q1_zero && q2_zero) begin
                if (bus.Reload_En) begin
                    q1_d = r1_q;
                    q2_d = r2_q;
                end else begin
                    q1_d = DigitMax;
                    q2_d = DigitMax;
                end
            end else begin
                q1_d = dec_digit(q1_q);
                if (q1_zero) begin
                    q2_d = dec_digit(q2_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q <= 4'd0;
            q2_q <= 4'd0;
            r1_q <= 4'd0;
            r2_q <= 4'd0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
        end
    end

    // Borrow ignores P so stages cascade like a ripple-carry chain.
    assign bus.Qout1     = q1_q;
    assign bus.Qout2     = q2_q;
    assign bus.Borrow[0] = bus.T & q1_zero;
    assign bus.Borrow[1] = bus.T & q1_zero & q2_zero;
    assign bus.Zero      = q1_zero & q2_zero;

endmodule

// File: tb/tb_counter_8bits_down.sv
// Bench for counter_8bits_down: binary and BCD instances driven in lockstep,
// compared against integer-valued reference models plus directed constants.
module tb_counter_8bits_down;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ld_n = 1'b1;
    logic       clr_n = 1'b1;
    logic       p = 1'b0;
    logic       t = 1'b0;
    logic       rel = 1'b0;
    logic [3:0] d1 = 4'd0;
    logic [3:0] d2 = 4'd0;

    int checks = 0;
    int errors = 0;

    // Reference state as plain integers: binary value 0..255, BCD value 0..159.
    int vb = 0, rb = 0, vd = 0, rd = 0;

    counter_8bits_down_if bin_if ();
    counter_8bits_down_if bcd_if ();

    assign bin_if.Load_N = ld_n;   assign bcd_if.Load_N = ld_n;
    assign bin_if.Clear_N = clr_n; assign bcd_if.Clear_N = clr_n;
    assign bin_if.P = p;           assign bcd_if.P = p;
    assign bin_if.T = t;           assign bcd_if.T = t;
    assign bin_if.Reload_En = rel; assign bcd_if.Reload_En = rel;
    assign bin_if.Din1 = d1;       assign bcd_if.Din1 = d1;
    assign bin_if.Din2 = d2;       assign bcd_if.Din2 = d2;

    counter_8bits_down #(.BCD(0)) u_bin (.clk(clk), .rst(rst), .bus(bin_if.slave));
    counter_8bits_down #(.BCD(1)) u_bcd (.clk(clk), .rst(rst), .bus(bcd_if.slave));

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_bin_q();
        return 8'(vb);
    endfunction

    function automatic logic [7:0] exp_bcd_q();
        logic [3:0] tens, ones;
        tens = 4'(vd / 10);
        ones = 4'(vd % 10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] exp_borrow(input int v, input int radix);
        if (!t) return 8'd0;
        if (v == 0) return 8'd3;
        if ((v % radix) == 0) return 8'd1;
        return 8'd0;
    endfunction

    task automatic model_edge();
        if (!clr_n) begin
            vb = 0;
            vd = 0;
        end else if (!ld_n) begin
            vb = int'(d2) * 16 + int'(d1);
            vd = int'(d2) * 10 + int'(d1);
            rb = vb;
            rd = vd;
        end else if (p && t) begin
            vb = (vb == 0) ? (rel ? rb : 255) : vb - 1;
            vd = (vd == 0) ? (rel ? rd : 99) : vd - 1;
        end
    endtask

    task automatic check_models();
        check8("bin_q", {bin_if.Qout2, bin_if.Qout1}, exp_bin_q());
        check8("bin_borrow", {6'd0, bin_if.Borrow}, exp_borrow(vb, 16));
        check8("bin_zero", {7'd0, bin_if.Zero}, {7'd0, vb == 0});
        check8("bcd_q", {bcd_if.Qout2, bcd_if.Qout1}, exp_bcd_q());
        check8("bcd_borrow", {6'd0, bcd_if.Borrow}, exp_borrow(vd, 10));
        check8("bcd_zero", {7'd0, bcd_if.Zero}, {7'd0, vd == 0});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_models();
    endtask

    initial begin
        int b1_cnt;
        int bad_digit;
        logic [7:0] seq [8];

        // Reset release, then asynchronous reset from a loaded 0x5A.
        #12 rst = 1'b0;
        @(negedge clk);
        ld_n = 1'b0; d2 = 4'h5; d1 = 4'hA;
        @(posedge clk); #1;
        check8("load_5a", {bin_if.Qout2, bin_if.Qout1}, 8'h5A);
        ld_n = 1'b1;
        #2 rst = 1'b1;
        #1;
        check8("async_rst_bin", {bin_if.Qout2, bin_if.Qout1}, 8'h00);
        check8("async_rst_bcd", {bcd_if.Qout2, bcd_if.Qout1}, 8'h00);
        t = 1'b1; #1;
        check8("rst_zero", {7'd0, bin_if.Zero}, 8'd1);
        check8("rst_borrow_t1", {6'd0, bin_if.Borrow}, 8'd3);
        t = 1'b0; #1;
        check8("rst_borrow_t0", {6'd0, bin_if.Borrow}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        vb = 0; vd = 0; rb = 0; rd = 0;

        // First count after reset is terminal with Reload_En=0.
        p = 1'b1; t = 1'b1; rel = 1'b0;
        cyc();
        check8("post_rst_wrap_bin", {bin_if.Qout2, bin_if.Qout1}, 8'hFF);
        check8("post_rst_wrap_bcd", {bcd_if.Qout2, bcd_if.Qout1}, 8'h99);

        // Binary digit ripple through 0x10 and wrap through 0x00.
        ld_n = 1'b0; d2 = 4'h1; d1 = 4'h0;
        cyc();
        check8("at_10_borrow", {6'd0, bin_if.Borrow}, 8'd1);
        ld_n = 1'b1;
        cyc();
        check8("q_0f", {bin_if.Qout2, bin_if.Qout1}, 8'h0F);
        check8("q_0f_borrow", {6'd0, bin_if.Borrow}, 8'd0);
        cyc();
        check8("q_0e", {bin_if.Qout2, bin_if.Qout1}, 8'h0E);
        ld_n = 1'b0; d2 = 4'h0; d1 = 4'h1;
        cyc();
        ld_n = 1'b1;
        cyc();
        check8("q_00_borrow", {6'd0, bin_if.Borrow}, 8'd3);
        cyc();
        check8("q_ff", {bin_if.Qout2, bin_if.Qout1}, 8'hFF);

        // BCD: 20 down to 00 then wrap to 99.
        ld_n = 1'b0; d2 = 4'd2; d1 = 4'd0;
        cyc();
        ld_n = 1'b1;
        b1_cnt = 0;
        bad_digit = 0;
        for (int i = 0; i < 21; i++) begin
            cyc();
            if (bcd_if.Borrow[1]) b1_cnt++;
            if (bcd_if.Qout1 > 4'd9) bad_digit++;
        end
        check8("bcd_final_99", {bcd_if.Qout2, bcd_if.Qout1}, 8'h99);
        check8("bcd_borrow1_once", 8'(b1_cnt), 8'd1);
        check8("bcd_digit_range", 8'(bad_digit), 8'd0);

        // Auto-reload divide-by-4.
        rel = 1'b1;
        ld_n = 1'b0; d2 = 4'h0; d1 = 4'h3;
        cyc();
        ld_n = 1'b1;
        seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
        b1_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check8("reload_seq", {bin_if.Qout2, bin_if.Qout1}, seq[i]);
            if (bin_if.Borrow[1]) b1_cnt++;
        end
        check8("reload_borrow1", 8'(b1_cnt), 8'd2);
        clr_n = 1'b0;
        cyc();
        check8("clear", {bin_if.Qout2, bin_if.Qout1}, 8'h00);
        clr_n = 1'b1;
        cyc();
        check8("clear_then_reload", {bin_if.Qout2, bin_if.Qout1}, 8'h03);

        // Enables and clear-over-load priority.
        ld_n = 1'b0; d2 = 4'h1; d1 = 4'h0;
        cyc();
        ld_n = 1'b1; p = 1'b0; t = 1'b1;
        cyc();
        check8("hold_p0", {bin_if.Qout2, bin_if.Qout1}, 8'h10);
        check8("hold_p0_borrow", {6'd0, bin_if.Borrow}, 8'd1);
        p = 1'b1; t = 1'b0;
        cyc();
        check8("hold_t0", {bin_if.Qout2, bin_if.Qout1}, 8'h10);
        check8("hold_t0_borrow", {6'd0, bin_if.Borrow}, 8'd0);
        t = 1'b1; clr_n = 1'b0; ld_n = 1'b0; d2 = 4'h7; d1 = 4'h7;
        cyc();
        check8("clr_beats_load", {bin_if.Qout2, bin_if.Qout1}, 8'h00);
        clr_n = 1'b1; ld_n = 1'b1;
        cyc();
        check8("reload_kept_bin", {bin_if.Qout2, bin_if.Qout1}, 8'h10);
        check8("reload_kept_bcd", {bcd_if.Qout2, bcd_if.Qout1}, 8'h10);

        // Non-BCD upper digit in BCD mode decrements into range.
        ld_n = 1'b0; d2 = 4'hC; d1 = 4'h0;
        cyc();
        ld_n = 1'b1;
        cyc();
        check8("nonbcd_bcd", {bcd_if.Qout2, bcd_if.Qout1}, 8'hB9);
        check8("nonbcd_bin", {bin_if.Qout2, bin_if.Qout1}, 8'hBF);

        // Randomized control, lower load digit kept 0..9 so both radices model cleanly.
        for (int i = 0; i < 400; i++) begin
            d1    = 4'($urandom_range(9));
            d2    = 4'($urandom_range(15));
            clr_n = ($urandom_range(19) != 0);
            ld_n  = ($urandom_range(11) != 0);
            p     = ($urandom_range(4) != 0);
            t     = ($urandom_range(4) != 0);
            rel   = 1'($urandom_range(1));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_8bits_down.md
Name: counter_8bits_down

Overview:
- 8-bit synchronous down counter built from two cascaded 4-bit digit stages, lower and upper.
- Shares the control style of the team's 8-bit up-counter family: active-low load and clear, P/T count enables, per-stage ripple outputs.
- Counts down instead of up, and emits borrow instead of carry.
- Adds an auto-reload register so it works as a programmable divider/timer, with optional BCD (00-99) digit mode.

Parameters:
- BCD, 0, 0 = binary digits (each stage 0-15, full range 255..0); 1 = BCD digits (each stage 0-9, range 99..00).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Load_N  input  1  synchronous parallel load, active low.
- Clear_N  input  1  synchronous clear, active low.
- P  input  1  count enable (gates counting only).
- T  input  1  count enable (gates counting and the borrow outputs).
- Reload_En  input  1  1 = on terminal count, reload from the reload register instead of wrapping.
- Din1  input  4  load value, lower digit.
- Din2  input  4  load value, upper digit.
- Qout1  output  4  lower digit count.
- Qout2  output  4  upper digit count.
- Borrow  output  2  [0] = lower-stage borrow, [1] = full 8-bit borrow (terminal count).
- Zero  output  1  1 when Qout2 and Qout1 are both 0, independent of T.

Behaviour:
- Reset:
  - rst=1 forces Qout1=0, Qout2=0 and reload register {R2,R1}=0 immediately, without waiting for clk.
  - Outputs then follow the combinational rules below: Zero=1, Borrow=T?2'b11:2'b00.
- Synchronous priority at each rising clk edge, highest first:
  1. Clear_N=0: Qout1=Qout2=0. Reload register unchanged.
  2. Load_N=0: Qout1=Din1, Qout2=Din2, and R1=Din1, R2=Din2 in the same edge.
  3. P=1 and T=1: decrement step.
  4. Otherwise: hold.
- Decrement step, per stage:
  - Lower stage always steps.
  - Upper stage steps only when Qout1 is at its minimum (0).
  - Step rule: a digit at 0 wraps to 15 (BCD=0) or 9 (BCD=1); any other value v becomes v-1.
- Terminal count is Qout2=0 and Qout1=0 with P=T=1:
  - Reload_En=0: both digits wrap, to 0xFF (binary) or 9/9 (BCD).
  - Reload_En=1: Qout1=R1, Qout2=R2.
  - Reload value {0,0}: the counter stays at 0.
  - A divide-by-N period is therefore N+1 clocks for a loaded value N.
- Borrow outputs are combinational, mirroring the up-counter ripple-carry convention:
  - Borrow[0] = T & (Qout1==0).
  - Borrow[1] = T & (Qout1==0) & (Qout2==0).
  - P does not gate the borrow outputs, so stages can be cascaded as in the 74163 scheme.
- Zero = (Qout1==0)&(Qout2==0), ungated.
- BCD=1 with a non-BCD value loaded (digit 10-15):
  - The digit decrements normally (e.g. 0xC→0xB→…→9) and enters the 9..0 range.
  - Wrap is always to 9.
  - No error flag.
- Simultaneous Clear_N=0 and Load_N=0: clear wins, and the reload register is not updated.
- Reset asserted mid-count: state is lost. After release, counting resumes from 0, so the first P=T=1 edge is a terminal-count event governed by Reload_En (reload register is also 0).
- Counting, wrap and reload all take effect on the clock edge. Borrow and Zero reflect the new Q in the same cycle after the edge, with zero latency from Q.

Test Plan:
- rst pulse mid-cycle with Q=0x5A: Q goes to 0x00 without a clk edge; Zero=1; with T=1, Borrow=2'b11; with T=0, Borrow=2'b00.
- BCD=0: load Din2=1, Din1=0; count 2 clocks with Reload_En=0 → Q=0x0F then 0x0E; Borrow[0]=1 only while Q=0x10; count 0x01→0x00→0xFF with Borrow[1]=1 during 0x00.
- BCD=1: load 2/0 (20); count 21 clocks → 20,19,18,…,00,99; Qout1 never shows 10-15; Borrow[1]=1 exactly one cycle (at 00).
- Reload_En=1, load 0x03: P=T=1 continuous → sequence 3,2,1,0,3,2,… (period 4); Borrow[1] pulses once every 4 clocks; Clear_N pulse sets Q=0 and the next count reloads to 3.
- Enables: Q=0x10, P=0/T=1 → hold, Borrow=2'b01; P=1/T=0 → hold, Borrow=2'b00; Load_N=0 with Clear_N=0 and Din=0x77 → Q=0x00, later reload restores the previously loaded value, not 0x77.
